gamma_lut_loader: RTL
=====================

Name: gamma_lut_loader

Overview:
- Sequences loading of gamma curves into the double-banked per-plane LUT RAM read by the gamma corrector.
- Host streams one plane's curve at a time into the shadow bank. On commit, the block swaps the active bank at the next start-of-frame, so a frame never mixes curves.
- Sits between the host configuration interface and the corrector's LUT write port and bank select.

Parameters:
- DATA_W, 12, width of LUT entries (matches corrector plane width)
- ADDR_W, 8, LUT address width; LUT_DEPTH = 2**ADDR_W entries per plane per bank
- NPLANES, 3, number of colour planes

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse: begin loading one plane into the shadow bank
- load_plane  in  2  plane index for load_start; valid 0..NPLANES-1
- cfg_valid  in  1  curve word valid
- cfg_ready  out  1  loader accepts curve word
- cfg_data  in  DATA_W  curve word, written in ascending address order
- commit  in  1  pulse: request bank swap at the next sof
- sof  in  1  start-of-frame pulse from the video timing
- err_clr  in  1  clears err
- lut_we  out  1  LUT write enable
- lut_bank  out  1  bank written (always the shadow bank)
- lut_plane  out  2  plane written
- lut_addr  out  ADDR_W  LUT write address
- lut_wdata  out  DATA_W  LUT write data
- active_bank  out  1  bank the corrector reads
- busy  out  1  state != IDLE
- load_done  out  1  one-cycle pulse when the last word of a plane is accepted
- swap_done  out  1  one-cycle pulse when active_bank toggles
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE; active_bank=0; addr counter=0; commit_seen=0.
  - All outputs 0: cfg_ready, lut_we, lut_bank, lut_plane, lut_addr, lut_wdata, busy, load_done, swap_done, err.
  - Reset asserted mid-load or mid-pend abandons the operation with no swap.
- States: IDLE, LOAD, PEND.
- IDLE:
  - load_start with load_plane<NPLANES: latch plane, addr=0, go to LOAD.
  - load_start with load_plane>=NPLANES: set err, stay in IDLE.
  - commit: go to PEND.
  - load_start and commit in the same cycle: load wins, and commit_seen is set.
- LOAD:
  - cfg_ready=1. The cycle after each handshake (cfg_valid & cfg_ready), lut_we=1 with lut_addr=addr, lut_wdata=cfg_data, lut_plane=latched plane, lut_bank=~active_bank. Write latency is 1 cycle.
  - addr increments per accepted word.
  - On the handshake at addr=LUT_DEPTH-1: load_done pulses the same cycle. Next state is PEND if commit_seen or commit is asserted that cycle, else IDLE. commit_seen is then cleared.
  - commit during LOAD sets commit_seen; the load is not interrupted.
  - load_start during LOAD is ignored and sets err.
  - cfg_valid bubbles are allowed; addr holds while cfg_valid=0.
- PEND:
  - cfg_ready=0.
  - First sof strictly after entering PEND: active_bank toggles, swap_done pulses that cycle, go to IDLE.
  - load_start during PEND is rejected (shadow bank is frozen) and sets err.
  - Extra commit pulses in PEND are absorbed.
- Outside LOAD: cfg_ready=0; cfg_valid is ignored, words are not consumed, and no error is raised.
- err stays set until err_clr. err_clr and a new error in the same cycle leave err set.
- busy is combinational from the state register.
- lut_bank and lut_wdata hold their last values when lut_we=0.

Decomposition:
- Shared package gamma_pkg:
  - DATA_W and NPLANES constants
  - State enum {IDLE, LOAD, PEND}
  - Plane index type
- Optional sub-module gamma_lut_wr_port: the 1-cycle registered write-port stage (we/addr/data/plane/bank). The FSM stays in gamma_lut_loader.

Test Plan:
- ADDR_W=4; reset; load_start plane=1, stream 16 words 0x000..0x00F without gaps -> 16 lut_we cycles, each 1 cycle after its handshake, with addr 0..15, bank=1, plane=1; load_done on the 16th handshake; back to IDLE; active_bank stays 0.
- Same load with cfg_valid toggling every other cycle -> addresses still 0..15, contiguous, with no duplicates or skips.
- commit asserted at word 8 of a load; sof pulses at words 10 and 20 -> no swap on the word-10 sof; after the last word, state is PEND; swap happens on the sof after it, active_bank=1, one swap_done pulse.
- commit and sof in the same cycle from IDLE -> no swap that cycle; swap on the next sof.
- load_start during PEND, and load_plane=3 in IDLE -> err=1, no lut_we, state unchanged; err_clr -> err=0.
- rst asserted at word 5 of a load -> all outputs 0, active_bank=0 immediately; a subsequent full load writes from addr 0.

Source files
------------

// File: rtl/gamma_pkg.sv
// ---------------------------------------------------------------------------
// gamma_pkg : shared constants, state encoding and plane type for the
//             gamma LUT loader.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gamma_pkg;

  localparam int DATA_W  = 12;
  localparam int NPLANES = 3;
  localparam int PLANE_W = 2;

  typedef logic [PLANE_W-1:0] plane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_e;

  function automatic logic plane_ok(input plane_t p, input int nplanes);
    return int'(p) < nplanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gamma_lut_wr_port.sv
// ---------------------------------------------------------------------------
// gamma_lut_wr_port : one-cycle registered LUT write stage.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gamma_lut_wr_port
  import gamma_pkg::*;
#(
  parameter int DATA_W = gamma_pkg::DATA_W,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  plane_t            plane_i,
  input  logic              bank_i,
  output logic              lut_we_o,
  output logic [ADDR_W-1:0] lut_addr_o,
  output logic [DATA_W-1:0] lut_wdata_o,
  output plane_t            lut_plane_o,
  output logic              lut_bank_o
);

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  plane_t            plane_q;
  logic              bank_q;

  // Address/data/plane/bank only move on a write so the RAM port sees stable values otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      plane_q <= '0;
      bank_q  <= 1'b0;
    end else begin
      we_q <= we_i;
      if (we_i) begin
        addr_q  <= addr_i;
        data_q  <= data_i;
        plane_q <= plane_i;
        bank_q  <= bank_i;
      end
    end
  end

  assign lut_we_o    = we_q;
  assign lut_addr_o  = addr_q;
  assign lut_wdata_o = data_q;
  assign lut_plane_o = plane_q;
  assign lut_bank_o  = bank_q;

endmodule

`default_nettype wire

// File: rtl/gamma_lut_loader.sv
// ---------------------------------------------------------------------------
// gamma_lut_loader : streams host gamma curves into the shadow LUT bank and
//                    swaps banks at start-of-frame after a commit.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gamma_lut_loader
  import gamma_pkg::*;
#(
  parameter int DATA_W  = gamma_pkg::DATA_W,
  parameter int ADDR_W  = 8,
  parameter int NPLANES = gamma_pkg::NPLANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start_i,
  input  logic [1:0]        load_plane_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [DATA_W-1:0] cfg_data_i,
  input  logic              commit_i,
  input  logic              sof_i,
  input  logic              err_clr_i,
  output logic              lut_we_o,
  output logic              lut_bank_o,
  output logic [1:0]        lut_plane_o,
  output logic [ADDR_W-1:0] lut_addr_o,
  output logic [DATA_W-1:0] lut_wdata_o,
  output logic              active_bank_o,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              swap_done_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  plane_t            plane_q, plane_d;
  logic              commit_seen_q, commit_seen_d;
  logic              active_bank_q, active_bank_d;
  logic              err_q, err_d;
  logic              new_err;
  logic              hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      plane_q       <= '0;
      commit_seen_q <= 1'b0;
      active_bank_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      plane_q       <= plane_d;
      commit_seen_q <= commit_seen_d;
      active_bank_q <= active_bank_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    plane_d       = plane_q;
    commit_seen_d = commit_seen_q;
    active_bank_d = active_bank_q;
    new_err       = 1'b0;
    hs            = 1'b0;
    cfg_ready_o   = 1'b0;
    load_done_o   = 1'b0;
    swap_done_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start_i && plane_ok(load_plane_i, NPLANES)) begin
          plane_d       = load_plane_i;
          addr_d        = '0;
          commit_seen_d = commit_i;
          state_d       = LOAD;
        end else begin
          if (load_start_i) new_err = 1'b1;
          if (commit_i)     state_d = PEND;
        end
      end

      LOAD: begin
        cfg_ready_o = 1'b1;
        hs          = cfg_valid_i;
        if (load_start_i) new_err = 1'b1;
        if (commit_i)     commit_seen_d = 1'b1;
        if (hs) begin
          addr_d = addr_q + ADDR_W'(1);
          // Last word: a commit seen at any point in the load (or now) arms the swap.
          if (&addr_q) begin
            load_done_o   = 1'b1;
            state_d       = (commit_seen_q || commit_i) ? PEND : IDLE;
            commit_seen_d = 1'b0;
          end
        end
      end

      PEND: begin
        if (load_start_i) new_err = 1'b1;
        if (sof_i) begin
          active_bank_d = ~active_bank_q;
          swap_done_o   = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    err_d = (err_q && !err_clr_i) || new_err;
  end

  gamma_lut_wr_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_port (
    .clk         (clk),
    .rst         (rst),
    .we_i        (hs),
    .addr_i      (addr_q),
    .data_i      (cfg_data_i),
    .plane_i     (plane_q),
    .bank_i      (~active_bank_q),
    .lut_we_o    (lut_we_o),
    .lut_addr_o  (lut_addr_o),
    .lut_wdata_o (lut_wdata_o),
    .lut_plane_o (lut_plane_o),
    .lut_bank_o  (lut_bank_o)
  );

  assign active_bank_o = active_bank_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

endmodule

`default_nettype wire
